mpt_plb: RTL and testbench

//  Parametrised, fully-associative Permission Lookaside Buffer (PLB) caching MPT leaf permissions per
//  (SDID, 4 KiB page). Sits between the access pipeline and the MPT walker: lookups hit here, misses
//  go to the walker, whose results are written back via the fill port. Adds SDID-selective flush,

---
 rtl/mpt_pkg.sv | 53 +++++
 rtl/mpt_plb_victim_sel.sv | 59 +++++
 rtl/mpt_plb.sv | 221 ++++++++++++++++++++++
 tb/tb_mpt_plb.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mpt_pkg.sv
// Shared MPT types: access kinds, permission encodings, PLB entry/request records
// and the permission check used by both the PLB and the MPT walker.
package mpt_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned SDID_LEN = 6;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } mpt_access_e;

    // Bit 0 = read, bit 1 = write, bit 2 = execute.
    typedef enum logic [2:0] {
        ALLOW_NONE = 3'b000,
        ALLOW_R    = 3'b001,
        ALLOW_W    = 3'b010,
        ALLOW_RW   = 3'b011,
        ALLOW_X    = 3'b100,
        ALLOW_RX   = 3'b101,
        ALLOW_WX   = 3'b110,
        ALLOW_RWX  = 3'b111
    } mpt_permissions_e;

    typedef struct packed {
        logic [SDID_LEN-1:0] sdid;
        logic [XLEN-1:0]     spa;
        mpt_permissions_e    perms;
    } plb_entry_t;

    typedef struct packed {
        logic [SDID_LEN-1:0] sdid;
        logic [XLEN-1:0]     spa;
        mpt_access_e         access_type;
    } plb_lookup_req_t;

    function automatic logic plb_perm_allowed(input mpt_permissions_e perms,
                                              input mpt_access_e      access_type);
        logic [2:0] p;
        logic       ok;
        p = perms;
        case (access_type)
            ACCESS_READ:  ok = p[0];
            ACCESS_WRITE: ok = p[1];
            ACCESS_EXEC:  ok = p[2];
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mpt_plb_victim_sel.sv
// Replacement helper: lowest-index invalid slot plus a round-robin eviction
// pointer that only moves when a valid entry is actually evicted.
module mpt_plb_victim_sel
    import mpt_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_ENTRIES-1:0] valid_i,
    input  logic                   evict_i,
    input  logic                   clear_i,
    output logic                   any_invalid_o,
    output logic [IDX_W-1:0]       first_invalid_o,
    output logic [IDX_W-1:0]       victim_o
);

    logic [IDX_W-1:0] victim_d;
    logic [IDX_W-1:0] victim_q;

    // Priority search: scanning downwards leaves the lowest invalid index.
    always_comb begin
        any_invalid_o   = 1'b0;
        first_invalid_o = {IDX_W{1'b0}};
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                any_invalid_o   = 1'b1;
                first_invalid_o = IDX_W'(i);
            end else begin
                any_invalid_o   = any_invalid_o;
            end
        end
    end

    // Pointer wraps naturally because NUM_ENTRIES is a power of two.
    always_comb begin
        victim_d = victim_q;
        if (clear_i) begin
            victim_d = {IDX_W{1'b0}};
        end else if (evict_i) begin
            victim_d = victim_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            victim_d = victim_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            victim_q <= {IDX_W{1'b0}};
        end else begin
            victim_q <= victim_d;
        end
    end

    assign victim_o = victim_q;

endmodule

// File: rtl/mpt_plb.sv
// Fully-associative permission lookaside buffer caching MPT leaf permissions
// per (SDID, page), with selective flush, in-place refill and hit/miss counters.
module mpt_plb
    import mpt_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES   = 8,
    parameter int unsigned PAGE_OFFSET_W = 12,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           lookup_valid_i,
    output logic                           lookup_ready_o,
    input  plb_lookup_req_t                lookup_req_i,
    output logic                           resp_valid_o,
    output logic                           resp_hit_o,
    output mpt_permissions_e               resp_perms_o,
    output logic                           resp_allowed_o,
    input  logic                           fill_valid_i,
    input  plb_entry_t                     fill_entry_i,
    input  logic                           flush_i,
    input  logic                           flush_sdid_en_i,
    input  logic [SDID_LEN-1:0]            flush_sdid_i,
    output logic [$clog2(NUM_ENTRIES):0]   occupancy_o,
    output logic [CNT_W-1:0]               hit_cnt_o,
    output logic [CNT_W-1:0]               miss_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned OCC_W = IDX_W + 1;
    localparam int unsigned TAG_W = XLEN - PAGE_OFFSET_W;

    logic [NUM_ENTRIES-1:0] valid_d, valid_q;
    logic [SDID_LEN-1:0]    sdid_d  [NUM_ENTRIES];
    logic [SDID_LEN-1:0]    sdid_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_d   [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_q   [NUM_ENTRIES];
    mpt_permissions_e       perms_d [NUM_ENTRIES];
    mpt_permissions_e       perms_q [NUM_ENTRIES];

    logic                   resp_valid_d, resp_valid_q;
    logic                   resp_hit_d, resp_hit_q;
    mpt_permissions_e       resp_perms_d, resp_perms_q;
    logic                   resp_allowed_d, resp_allowed_q;
    logic [OCC_W-1:0]       occupancy_d, occupancy_q;
    logic [CNT_W-1:0]       hit_cnt_d, hit_cnt_q;
    logic [CNT_W-1:0]       miss_cnt_d, miss_cnt_q;

    logic [TAG_W-1:0]       lk_tag_s, fill_tag_s;
    logic [NUM_ENTRIES-1:0] lk_match_s, fill_match_s;
    logic [IDX_W-1:0]       lk_idx_s, fill_idx_s, tgt_idx_s;
    logic                   lk_hit_s, fill_hit_s, lk_accept_s;
    logic                   any_invalid_s, evict_s, full_flush_s;
    logic [IDX_W-1:0]       first_invalid_s, victim_s;

    assign lk_tag_s     = lookup_req_i.spa[XLEN-1:PAGE_OFFSET_W];
    assign fill_tag_s   = fill_entry_i.spa[XLEN-1:PAGE_OFFSET_W];
    assign lk_accept_s  = lookup_valid_i & ~flush_i;
    assign full_flush_s = flush_i & ~flush_sdid_en_i;

    // Match vectors for the lookup and fill ports, one-hot encoded to an index.
    always_comb begin
        lk_match_s   = {NUM_ENTRIES{1'b0}};
        fill_match_s = {NUM_ENTRIES{1'b0}};
        lk_idx_s     = {IDX_W{1'b0}};
        fill_idx_s   = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            lk_match_s[i]   = valid_q[i] && (sdid_q[i] == lookup_req_i.sdid) && (tag_q[i] == lk_tag_s);
            fill_match_s[i] = valid_q[i] && (sdid_q[i] == fill_entry_i.sdid) && (tag_q[i] == fill_tag_s);
            if (lk_match_s[i]) begin
                lk_idx_s = lk_idx_s | IDX_W'(i);
            end else begin
                lk_idx_s = lk_idx_s;
            end
            if (fill_match_s[i]) begin
                fill_idx_s = fill_idx_s | IDX_W'(i);
            end else begin
                fill_idx_s = fill_idx_s;
            end
        end
        lk_hit_s   = |lk_match_s;
        fill_hit_s = |fill_match_s;
    end

    // Replacement target: matching entry, else first invalid, else round-robin victim.
    always_comb begin
        evict_s = 1'b0;
        if (fill_hit_s) begin
            tgt_idx_s = fill_idx_s;
        end else if (any_invalid_s) begin
            tgt_idx_s = first_invalid_s;
        end else begin
            tgt_idx_s = victim_s;
            evict_s   = fill_valid_i & ~flush_i;
        end
    end

    mpt_plb_victim_sel #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_victim_sel (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .valid_i         (valid_q),
        .evict_i         (evict_s),
        .clear_i         (full_flush_s),
        .any_invalid_o   (any_invalid_s),
        .first_invalid_o (first_invalid_s),
        .victim_o        (victim_s)
    );

    // Entry array update; a flush wins over a same-cycle fill, which is dropped.
    always_comb begin
        valid_d = valid_q;
        sdid_d  = sdid_q;
        tag_d   = tag_q;
        perms_d = perms_q;
        if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (!flush_sdid_en_i || (sdid_q[i] == flush_sdid_i)) begin
                    valid_d[i] = 1'b0;
                end else begin
                    valid_d[i] = valid_q[i];
                end
            end
        end else if (fill_valid_i) begin
            valid_d[tgt_idx_s] = 1'b1;
            sdid_d[tgt_idx_s]  = fill_entry_i.sdid;
            tag_d[tgt_idx_s]   = fill_tag_s;
            perms_d[tgt_idx_s] = fill_entry_i.perms;
        end else begin
            valid_d = valid_q;
        end
    end

    // Occupancy is counted from the next state so the register tracks the array.
    always_comb begin
        occupancy_d = {OCC_W{1'b0}};
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occupancy_d = occupancy_d + {{(OCC_W-1){1'b0}}, valid_d[i]};
        end
    end

    // Response capture and saturating statistics; responses hold while idle.
    always_comb begin
        resp_valid_d   = lk_accept_s;
        resp_hit_d     = resp_hit_q;
        resp_perms_d   = resp_perms_q;
        resp_allowed_d = resp_allowed_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        if (lk_accept_s) begin
            resp_hit_d     = lk_hit_s;
            resp_perms_d   = lk_hit_s ? perms_q[lk_idx_s] : ALLOW_NONE;
            resp_allowed_d = lk_hit_s && plb_perm_allowed(perms_q[lk_idx_s], lookup_req_i.access_type);
            if (lk_hit_s) begin
                if (hit_cnt_q != {CNT_W{1'b1}}) begin
                    hit_cnt_d = hit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
            end else begin
                if (miss_cnt_q != {CNT_W{1'b1}}) begin
                    miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    miss_cnt_d = miss_cnt_q;
                end
            end
        end else begin
            resp_hit_d = resp_hit_q;
        end
    end

    // Entry array registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= {NUM_ENTRIES{1'b0}};
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                sdid_q[i]  <= {SDID_LEN{1'b0}};
                tag_q[i]   <= {TAG_W{1'b0}};
                perms_q[i] <= ALLOW_NONE;
            end
        end else begin
            valid_q <= valid_d;
            sdid_q  <= sdid_d;
            tag_q   <= tag_d;
            perms_q <= perms_d;
        end
    end

    // Response, occupancy and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_perms_q   <= ALLOW_NONE;
            resp_allowed_q <= 1'b0;
            occupancy_q    <= {OCC_W{1'b0}};
            hit_cnt_q      <= {CNT_W{1'b0}};
            miss_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            resp_valid_q   <= resp_valid_d;
            resp_hit_q     <= resp_hit_d;
            resp_perms_q   <= resp_perms_d;
            resp_allowed_q <= resp_allowed_d;
            occupancy_q    <= occupancy_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign lookup_ready_o = ~flush_i;
    assign resp_valid_o   = resp_valid_q;
    assign resp_hit_o     = resp_hit_q;
    assign resp_perms_o   = resp_perms_q;
    assign resp_allowed_o = resp_allowed_q;
    assign occupancy_o    = occupancy_q;
    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_mpt_plb.sv
// Directed bench for mpt_plb (8 entries, 4-bit counters so saturation is reachable).
module tb_mpt_plb;
    import mpt_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  lookup_valid_i = 1'b0;
    logic                  lookup_ready_o;
    plb_lookup_req_t       lookup_req_i = '0;
    logic                  resp_valid_o, resp_hit_o, resp_allowed_o;
    mpt_permissions_e      resp_perms_o;
    logic                  fill_valid_i = 1'b0;
    plb_entry_t            fill_entry_i = '0;
    logic                  flush_i = 1'b0;
    logic                  flush_sdid_en_i = 1'b0;
    logic [SDID_LEN-1:0]   flush_sdid_i = '0;
    logic [$clog2(N):0]    occupancy_o;
    logic [CNT_W-1:0]      hit_cnt_o, miss_cnt_o;

    int vectors = 0;
    int errors  = 0;
    int hit_exp = 0;
    int miss_exp = 0;

    mpt_plb #(.NUM_ENTRIES(N), .PAGE_OFFSET_W(12), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o), .lookup_req_i(lookup_req_i),
        .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_perms_o(resp_perms_o),
        .resp_allowed_o(resp_allowed_o), .fill_valid_i(fill_valid_i), .fill_entry_i(fill_entry_i),
        .flush_i(flush_i), .flush_sdid_en_i(flush_sdid_en_i), .flush_sdid_i(flush_sdid_i),
        .occupancy_o(occupancy_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [SDID_LEN-1:0] sdid, input logic [63:0] spa, input mpt_permissions_e p);
        @(negedge clk_i);
        fill_valid_i = 1'b1;
        fill_entry_i = '{sdid: sdid, spa: spa, perms: p};
        @(negedge clk_i);
        fill_valid_i = 1'b0;
    endtask

    task automatic flush(input logic en, input logic [SDID_LEN-1:0] sdid);
        @(negedge clk_i);
        flush_i = 1'b1; flush_sdid_en_i = en; flush_sdid_i = sdid;
        @(negedge clk_i);
        flush_i = 1'b0; flush_sdid_en_i = 1'b0;
    endtask

    // Drives one lookup, checks the response one cycle later and the counters against the model.
    task automatic lookup(input string tag, input logic [SDID_LEN-1:0] sdid, input logic [63:0] spa,
                          input mpt_access_e acc, input logic e_hit, input logic [2:0] e_perms,
                          input logic e_allowed);
        @(negedge clk_i);
        lookup_valid_i = 1'b1;
        lookup_req_i   = '{sdid: sdid, spa: spa, access_type: acc};
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
        if (e_hit) hit_exp = (hit_exp == 15) ? 15 : hit_exp + 1;
        else       miss_exp = (miss_exp == 15) ? 15 : miss_exp + 1;
        check({tag, ".valid"},   64'(resp_valid_o), 64'd1);
        check({tag, ".hit"},     64'(resp_hit_o), 64'(e_hit));
        check({tag, ".perms"},   64'(resp_perms_o), 64'(e_perms));
        check({tag, ".allowed"}, 64'(resp_allowed_o), 64'(e_allowed));
        check({tag, ".hitcnt"},  64'(hit_cnt_o), 64'(hit_exp));
        check({tag, ".misscnt"}, 64'(miss_cnt_o), 64'(miss_exp));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.valid", 64'(resp_valid_o), 64'd0);
        check("rst.occ", 64'(occupancy_o), 64'd0);
        check("rst.hitcnt", 64'(hit_cnt_o), 64'd0);
        check("rst.ready", 64'(lookup_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: cold miss
        lookup("t1", 6'd3, 64'h8000_1234, ACCESS_READ, 1'b0, 3'b000, 1'b0);

        // 2: fill RX, exec allowed, write refused, other SDID misses, response holds
        fill(6'd3, 64'h8000_1000, ALLOW_RX);
        check("t2.occ", 64'(occupancy_o), 64'd1);
        lookup("t2.exec", 6'd3, 64'h8000_1FFC, ACCESS_EXEC, 1'b1, 3'b101, 1'b1);
        @(negedge clk_i);
        check("t2.hold_valid", 64'(resp_valid_o), 64'd0);
        check("t2.hold_hit", 64'(resp_hit_o), 64'd1);
        lookup("t2.write", 6'd3, 64'h8000_1FFC, ACCESS_WRITE, 1'b1, 3'b101, 1'b0);
        lookup("t2.sdid4", 6'd4, 64'h8000_1FFC, ACCESS_EXEC, 1'b0, 3'b000, 1'b0);
        lookup("t2.none", 6'd3, 64'h8000_1000, ACCESS_NONE, 1'b1, 3'b101, 1'b0);

        // 3: N+2 distinct pages; pages 0 and 1 evicted round-robin
        flush(1'b0, 6'd0);
        check("t3.occ0", 64'(occupancy_o), 64'd0);
        for (int k = 0; k < N + 2; k++) fill(6'd5, 64'h0010_0000 + (64'(k) << 12), ALLOW_R);
        check("t3.occ", 64'(occupancy_o), 64'(N));
        lookup("t3.p0", 6'd5, 64'h0010_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        lookup("t3.p1", 6'd5, 64'h0010_1000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        for (int k = 2; k < N + 2; k++)
            lookup("t3.pk", 6'd5, 64'h0010_0000 + (64'(k) << 12), ACCESS_READ, 1'b1, 3'b001, 1'b1);

        // 4: in-place refill, no duplicate
        fill(6'd5, 64'h0010_5000, ALLOW_RWX);
        check("t4.occ", 64'(occupancy_o), 64'(N));
        lookup("t4.write", 6'd5, 64'h0010_5ABC, ACCESS_WRITE, 1'b1, 3'b111, 1'b1);
        // full table + next fill evicts entry 2 (page 2), victim was at 2
        fill(6'd5, 64'h0020_0000, ALLOW_W);
        lookup("t4.evict2", 6'd5, 64'h0010_2000, ACCESS_READ, 1'b0, 3'b000, 1'b0);

        // 5: selective flush, flush-vs-fill, lookup blocked during flush, lookup-vs-fill
        flush(1'b0, 6'd0);
        fill(6'd1, 64'h2000_0000, ALLOW_RW);
        fill(6'd2, 64'h2000_0000, ALLOW_RX);
        check("t5.occ2", 64'(occupancy_o), 64'd2);
        @(negedge clk_i);
        flush_i = 1'b1; flush_sdid_en_i = 1'b1; flush_sdid_i = 6'd1;
        lookup_valid_i = 1'b1; lookup_req_i = '{sdid: 6'd2, spa: 64'h2000_0000, access_type: ACCESS_READ};
        #1 check("t5.ready", 64'(lookup_ready_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0; flush_sdid_en_i = 1'b0; lookup_valid_i = 1'b0;
        check("t5.noresp", 64'(resp_valid_o), 64'd0);
        check("t5.occ1", 64'(occupancy_o), 64'd1);
        lookup("t5.sdid1", 6'd1, 64'h2000_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        lookup("t5.sdid2", 6'd2, 64'h2000_0000, ACCESS_READ, 1'b1, 3'b101, 1'b1);
        @(negedge clk_i);
        flush_i = 1'b1; flush_sdid_en_i = 1'b1; flush_sdid_i = 6'd7;
        fill_valid_i = 1'b1; fill_entry_i = '{sdid: 6'd3, spa: 64'h3000_0000, perms: ALLOW_R};
        @(negedge clk_i);
        flush_i = 1'b0; flush_sdid_en_i = 1'b0; fill_valid_i = 1'b0;
        check("t5.ffocc", 64'(occupancy_o), 64'd1);
        lookup("t5.dropped", 6'd3, 64'h3000_0000, ACCESS_READ, 1'b0, 3'b000, 1'b0);
        @(negedge clk_i);
        fill_valid_i = 1'b1; fill_entry_i = '{sdid: 6'd3, spa: 64'h4000_0000, perms: ALLOW_X};
        lookup_valid_i = 1'b1; lookup_req_i = '{sdid: 6'd3, spa: 64'h4000_0010, access_type: ACCESS_EXEC};
        @(negedge clk_i);
        fill_valid_i = 1'b0; lookup_valid_i = 1'b0;
        miss_exp = (miss_exp == 15) ? 15 : miss_exp + 1;
        check("t5.nobypass", 64'(resp_hit_o), 64'd0);
        lookup("t5.after", 6'd3, 64'h4000_0010, ACCESS_EXEC, 1'b1, 3'b100, 1'b1);

        // 6: hit counter saturation
        for (int k = 0; k < 6; k++)
            lookup("t6.sat", 6'd3, 64'h4000_0000, ACCESS_EXEC, 1'b1, 3'b100, 1'b1);
        check("t6.hitF", 64'(hit_cnt_o), 64'hF);

        // async reset during a pending lookup
        @(negedge clk_i);
        lookup_valid_i = 1'b1; lookup_req_i = '{sdid: 6'd3, spa: 64'h4000_0000, access_type: ACCESS_EXEC};
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
        check("ar.valid", 64'(resp_valid_o), 64'd0);
        check("ar.occ", 64'(occupancy_o), 64'd0);
        check("ar.hitcnt", 64'(hit_cnt_o), 64'd0);
        rst_ni = 1'b1;
        hit_exp = 0; miss_exp = 0;
        lookup("ar.miss", 6'd3, 64'h4000_0000, ACCESS_EXEC, 1'b0, 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
